// File: rtl/input_sync_filt.sv
// rtl/input_sync_filt.sv - per-channel input synchroniser with run-length glitch filter and edge pulses
module input_sync_filt #(
  parameter int                  CHANNELS   = 3,
  parameter int                  STAGES     = 2,
  parameter int                  FILTER_LEN = 3,
  parameter logic [CHANNELS-1:0] RESET_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_edge
);

  localparam int             CW      = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(FILTER_LEN - 1);

  generate
    if (CHANNELS < 1 || STAGES < 2 || FILTER_LEN < 1) begin : g_bad_params
      $error("input_sync_filt: illegal parameter values");
    end
  endgenerate

  // chain_q[i][0] is the first capture flop, chain_q[i][STAGES-1] the settled sample
  logic [STAGES-1:0]   chain_q [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CHANNELS-1:0] s_vec;
  logic [CHANNELS-1:0] differ_vec;
  logic [CHANNELS-1:0] accept_vec;

  always_comb begin
    s_vec      = '0;
    differ_vec = '0;
    accept_vec = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      s_vec[i]      = chain_q[i][STAGES-1];
      differ_vec[i] = s_vec[i] != sync_out[i];
      accept_vec[i] = differ_vec[i] && (cnt_q[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        chain_q[i] <= {STAGES{RESET_VAL[i]}};
        cnt_q[i]   <= '0;
      end
      sync_out <= RESET_VAL;
      rise     <= '0;
      fall     <= '0;
      any_edge <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        chain_q[i] <= {chain_q[i][STAGES-2:0], async_in[i]};
        // a matching sample or an accepted change both start a fresh run
        if (!differ_vec[i] || accept_vec[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
        if (accept_vec[i]) begin
          sync_out[i] <= s_vec[i];
        end
      end
      rise     <= accept_vec & s_vec;
      fall     <= accept_vec & ~s_vec;
      any_edge <= |accept_vec;
    end
  end

endmodule

// File: tb/tb_input_sync_filt.sv
// tb/tb_input_sync_filt.sv - randomized self-checking bench for input_sync_filt
module tb_input_sync_filt;

  localparam int         CH  = 3;
  localparam int         STG = 2;
  localparam int         FL  = 3;
  localparam logic [2:0] RV  = 3'b100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] async_in = RV;
  logic [CH-1:0] sync_out, rise, fall;
  logic          any_edge;

  int checks = 0;
  int errors = 0;

  input_sync_filt #(
    .CHANNELS  (CH),
    .STAGES    (STG),
    .FILTER_LEN(FL),
    .RESET_VAL (RV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .async_in(async_in),
    .sync_out(sync_out),
    .rise    (rise),
    .fall    (fall),
    .any_edge(any_edge)
  );

  always #5 clk = ~clk;

  // Reference: a level is accepted once the last FL settled samples all disagree with it
  logic [2:0] m_pipe [STG];
  logic [2:0] m_hist [FL];
  logic [2:0] m_out, m_rise, m_fall;
  logic       m_any;

  task automatic tick();
    bit all_diff;
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < STG; k++) m_pipe[k] = RV;
      for (int k = 0; k < FL; k++) m_hist[k] = RV;
      m_out = RV; m_rise = '0; m_fall = '0; m_any = 1'b0;
    end else begin
      for (int k = FL - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = m_pipe[STG-1];
      m_rise = '0; m_fall = '0;
      for (int c = 0; c < CH; c++) begin
        all_diff = 1'b1;
        for (int k = 0; k < FL; k++) if (m_hist[k][c] == m_out[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_rise[c] = ~m_out[c];
          m_fall[c] = m_out[c];
          m_out[c]  = ~m_out[c];
        end
      end
      m_any = |{m_rise, m_fall};
      for (int k = STG - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = async_in;
    end
    #1;
  endtask

  task automatic test_reset();
    async_in = RV; rst = 1'b1;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if ({sync_out, rise, fall, any_edge} !== {RV, 3'b000, 3'b000, 1'b0}) begin
        errors++;
        $display("FAIL reset_during: out=%b rise=%b fall=%b any=%b required out=%b, no pulses", sync_out, rise, fall, any_edge, RV);
      end
    end
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if ({sync_out, rise, fall, any_edge} !== {RV, 3'b000, 3'b000, 1'b0}) begin
        errors++;
        $display("FAIL reset_after: out=%b rise=%b fall=%b any=%b required out=%b, no pulses", sync_out, rise, fall, any_edge, RV);
      end
    end
  endtask

  task automatic test_latency();
    async_in = 3'b110;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (e < 5 && (sync_out !== 3'b100 || rise !== 3'b000)) begin
        errors++;
        $display("FAIL latency_early E%0d: out=%b rise=%b required out=100 rise=000", e, sync_out, rise);
      end else if (e == 5 && {sync_out, rise, fall, any_edge} !== {3'b110, 3'b010, 3'b000, 1'b1}) begin
        errors++;
        $display("FAIL latency_edge E5: out=%b rise=%b fall=%b any=%b required 110/010/000/1", sync_out, rise, fall, any_edge);
      end else if (e == 6 && {rise, any_edge} !== 4'b0000) begin
        errors++;
        $display("FAIL latency_pulse_width E6: rise=%b any=%b required 000/0", rise, any_edge);
      end
    end
  endtask

  task automatic test_glitch();
    int rc, fc;
    async_in = 3'b111;
    tick(); tick();
    async_in = 3'b110;
    for (int n = 0; n < 8; n++) begin
      tick();
      checks++;
      if (sync_out[0] !== 1'b0 || rise[0] !== 1'b0 || fall[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch_2cyc: out0=%b rise0=%b fall0=%b required 0/0/0", sync_out[0], rise[0], fall[0]);
      end
    end
    rc = -1; fc = -1;
    async_in = 3'b111;
    for (int n = 1; n <= 15; n++) begin
      if (n == 4) async_in = 3'b110;
      tick();
      if (rise[0] === 1'b1) rc = n;
      if (fall[0] === 1'b1) fc = n;
    end
    checks++;
    if (rc != 5 || fc - rc != 3) begin
      errors++;
      $display("FAIL glitch_3cyc: rise at %0d fall at %0d required rise at 5, fall 3 cycles later", rc, fc);
    end
  endtask

  task automatic test_simultaneous();
    async_in = 3'b100;
    repeat (8) tick();
    async_in = 3'b011;
    for (int e = 1; e <= 5; e++) begin
      tick();
      checks++;
      if (e < 5 && any_edge !== 1'b0) begin
        errors++;
        $display("FAIL simul_early E%0d: any=%b required 0", e, any_edge);
      end else if (e == 5 && {sync_out, rise, fall, any_edge} !== {3'b011, 3'b011, 3'b100, 1'b1}) begin
        errors++;
        $display("FAIL simul_edge: out=%b rise=%b fall=%b any=%b required 011/011/100/1", sync_out, rise, fall, any_edge);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    async_in = 3'b100;
    repeat (8) tick();
    async_in = 3'b000;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (fall !== 3'b000 || sync_out !== 3'b100) begin
      errors++;
      $display("FAIL midrst_E4: out=%b fall=%b required 100/000", sync_out, fall);
    end
    rst = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      tick();
      checks++;
      if (r < 5 && (sync_out[2] !== 1'b1 || fall !== 3'b000)) begin
        errors++;
        $display("FAIL midrst_hold R%0d: out=%b fall=%b required out[2]=1 fall=000", r, sync_out, fall);
      end else if (r == 5 && {sync_out, fall} !== {3'b000, 3'b100}) begin
        errors++;
        $display("FAIL midrst_edge R5: out=%b fall=%b required 000/100", sync_out, fall);
      end else if (r == 6 && fall !== 3'b000) begin
        errors++;
        $display("FAIL midrst_width R6: fall=%b required 000", fall);
      end
    end
  endtask

  task automatic test_toggle();
    async_in = {2'($urandom_range(0, 3)), 1'b0};
    repeat (8) tick();
    for (int n = 0; n < 100; n++) begin
      async_in[0] = ~async_in[0];
      tick();
      checks++;
      if (sync_out[0] !== 1'b0 || rise[0] !== 1'b0 || fall[0] !== 1'b0 ||
          {sync_out, rise, fall, any_edge} !== {m_out, m_rise, m_fall, m_any}) begin
        errors++;
        $display("FAIL toggle n=%0d: out=%b rise=%b fall=%b any=%b required %b/%b/%b/%b, ch0 quiet",
                 n, sync_out, rise, fall, any_edge, m_out, m_rise, m_fall, m_any);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int n = 0; n < 600; n++) begin
      if (hold == 0) begin
        async_in = 3'($urandom);
        hold = $urandom_range(1, 5);
      end
      hold--;
      rst = ($urandom_range(0, 59) == 0);
      tick();
      checks++;
      if ({sync_out, rise, fall, any_edge} !== {m_out, m_rise, m_fall, m_any} ||
          (rise & fall) !== 3'b000) begin
        errors++;
        $display("FAIL random n=%0d: out=%b rise=%b fall=%b any=%b required %b/%b/%b/%b",
                 n, sync_out, rise, fall, any_edge, m_out, m_rise, m_fall, m_any);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < STG; k++) m_pipe[k] = RV;
    for (int k = 0; k < FL; k++) m_hist[k] = RV;
    m_out = RV; m_rise = '0; m_fall = '0; m_any = 1'b0;
    test_reset();
    test_latency();
    test_glitch();
    test_simultaneous();
    test_reset_mid_run();
    test_toggle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_sync_filt.md
INPUT_SYNC_FILT -- requirements
Module: input_sync_filt

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 3, the number of independent asynchronous inputs.
REQ-002 The block SHALL have parameter STAGES, default 2, the synchroniser flop depth per channel; the legal range is >= 2.
REQ-003 The block SHALL have parameter FILTER_LEN, default 3, the number of consecutive differing samples required to accept a level change; the legal range is >= 1.
REQ-004 The block SHALL have parameter RESET_VAL, width CHANNELS, default all-zero, the per-channel reset level.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the synchronous, active-high reset.
REQ-007 The block SHALL have port async_in, input, CHANNELS bits: the raw asynchronous inputs, e.g. SPI nCS/COPI/SCLK.
REQ-008 The block SHALL have port sync_out, output, CHANNELS bits: the synchronised, glitch-filtered level of each channel.
REQ-009 The block SHALL have port rise, output, CHANNELS bits: a one-cycle pulse when the corresponding sync_out goes 0->1.
REQ-010 The block SHALL have port fall, output, CHANNELS bits: a one-cycle pulse when the corresponding sync_out goes 1->0.
REQ-011 The block SHALL have port any_edge, output, 1 bit: the registered OR of all rise and fall bits.

Function
REQ-012 Each channel SHALL pass async_in[i] through a STAGES-deep flop chain; the last flop is the sample s[i]; there SHALL be no logic between chain flops.
REQ-013 Each channel SHALL keep a run counter cnt[i], $clog2(FILTER_LEN) bits wide with a minimum of 1 bit, which saturates at neither end beyond the rules below.
REQ-014 On each edge where s[i] == sync_out[i], cnt[i] SHALL clear to 0.
REQ-015 On each edge where s[i] != sync_out[i] and cnt[i] < FILTER_LEN-1, cnt[i] SHALL increment by 1.
REQ-016 On each edge where s[i] != sync_out[i] and cnt[i] == FILTER_LEN-1, sync_out[i] SHALL take s[i] and cnt[i] SHALL clear to 0.
REQ-017 When FILTER_LEN = 1, every differing sample SHALL be accepted on the next edge, giving pure synchroniser behaviour.
REQ-018 Latency SHALL be as follows: an async_in change captured at edge E1 appears on sync_out after edge E(STAGES+FILTER_LEN); the default is 5 edges.
REQ-019 A change at s[i] that persists for fewer than FILTER_LEN consecutive cycles SHALL NOT alter sync_out[i] and SHALL produce no pulse.
REQ-020 rise[i] and fall[i] SHALL be registered and asserted in the same cycle that sync_out[i] shows its new value, for exactly one cycle.
REQ-021 rise[i] and fall[i] SHALL never be asserted together.
REQ-022 any_edge SHALL be asserted in the cycle in which any rise or fall bit is asserted.
REQ-023 Channels SHALL be fully independent: simultaneous transitions on several channels SHALL yield simultaneous pulses, with no arbitration.
REQ-024 An input that toggles every cycle SHALL never change sync_out when FILTER_LEN >= 2.
REQ-025 Illegal parameter values (CHANNELS < 1, STAGES < 2, FILTER_LEN < 1) SHALL cause an elaboration-time error.

Reset
REQ-026 While rst = 1 at a rising edge, every chain flop and sync_out[i] SHALL load RESET_VAL[i], cnt SHALL load 0, and rise, fall and any_edge SHALL load 0.
REQ-027 Reset SHALL take priority over all other updates; reset asserted mid-filter-run SHALL discard the partial count and SHALL NOT produce a pulse.
REQ-028 After reset release with async_in[i] == RESET_VAL[i], no pulse SHALL occur.
REQ-029 After reset release with async_in[i] != RESET_VAL[i], a normal edge SHALL occur STAGES+FILTER_LEN edges after release.
REQ-030 The block SHALL have no asynchronous reset path and no reset synchroniser; rst is assumed already synchronous to clk.

Verification (CHANNELS=3, STAGES=2, FILTER_LEN=3, RESET_VAL=3'b100)
REQ-031 Reset check: assert rst for 2 cycles with async_in=3'b100 -> sync_out=3'b100, rise=fall=0, any_edge=0 during and after reset.
REQ-032 Latency check: async_in[1] goes 0->1 just before edge E1 and is held -> sync_out[1]=1 and rise=3'b010 for one cycle after edge E5, and sync_out is unchanged before E5.
REQ-033 Glitch rejection: a 2-cycle high pulse on async_in[0] -> sync_out[0] stays 0 and no rise or fall pulse occurs; a 3-cycle pulse -> rise[0] then fall[0], spaced 3 cycles apart.
REQ-034 Simultaneous edges: async_in changes 3'b100->3'b011 in one cycle -> in a single cycle rise=3'b011, fall=3'b100 and any_edge=1.
REQ-035 Reset mid-run: async_in[2] drops, then rst is asserted for 1 cycle at edge E4 -> no fall pulse at E4 or E5, and sync_out[2]=1 until STAGES+FILTER_LEN edges after release.
REQ-036 Toggle stress: async_in[0] toggles every clk for 100 cycles -> sync_out[0] constant and rise[0]=fall[0]=0 throughout.
